// File: rtl/irq_pend16.sv
// Pending-request collector feeding a 16-to-4 priority encoder.
// Edge-detected requests pend until acknowledged; a frozen masked snapshot is offered with irq.
module irq_pend16 #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          mask_we,
    input  logic [N-1:0]  mask_wd,
    input  logic          ack,
    input  logic [IW-1:0] ack_idx,
    output logic [N-1:0]  d,
    output logic          irq,
    output logic [N-1:0]  pend,
    output logic [N-1:0]  mask,
    output logic [N-1:0]  ovf,
    input  logic [N-1:0]  ovf_clr,
    output logic          ack_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_reg;
    logic [N-1:0]  req_q_reg;
    logic [N-1:0]  pend_reg;
    logic [N-1:0]  mask_reg;
    logic [N-1:0]  ovf_reg;
    logic [N-1:0]  d_reg;
    logic          irq_reg;
    logic          ack_err_reg;

    logic [N-1:0]  evt;
    logic [N-1:0]  clr_vec;
    logic [N-1:0]  pend_next;
    logic [N-1:0]  ovf_next;
    logic [N-1:0]  pend_masked;
    logic          ack_ok;

    assign evt         = req & ~req_q_reg;
    assign pend_masked = pend_reg & mask_reg;
    assign ack_ok      = (state_reg == REQ) && d_reg[ack_idx];

    // A new edge always wins over a same-cycle clear, and then it is not an overrun.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign clr_vec[gi]   = ack && ack_ok && (ack_idx == IW'(gi));
            assign pend_next[gi] = evt[gi] | (pend_reg[gi] & ~clr_vec[gi]);
            assign ovf_next[gi]  = (evt[gi] & pend_reg[gi] & ~clr_vec[gi])
                                 | (ovf_reg[gi] & ~ovf_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            req_q_reg   <= req;
            pend_reg    <= '0;
            mask_reg    <= '0;
            ovf_reg     <= '0;
            d_reg       <= '0;
            irq_reg     <= 1'b0;
            ack_err_reg <= 1'b0;
        end else begin
            req_q_reg   <= req;
            pend_reg    <= pend_next;
            ovf_reg     <= ovf_next;
            ack_err_reg <= ack && !ack_ok;
            if (mask_we) begin
                mask_reg <= mask_wd;
            end
            case (state_reg)
                IDLE: begin
                    if (|pend_masked) begin
                        d_reg     <= pend_masked;
                        irq_reg   <= 1'b1;
                        state_reg <= REQ;
                    end else begin
                        d_reg   <= '0;
                        irq_reg <= 1'b0;
                    end
                end
                REQ: begin
                    if (ack && ack_ok) begin
                        d_reg     <= '0;
                        irq_reg   <= 1'b0;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    d_reg     <= '0;
                    irq_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    d_reg     <= '0;
                    irq_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign d       = d_reg;
    assign irq     = irq_reg;
    assign pend    = pend_reg;
    assign mask    = mask_reg;
    assign ovf     = ovf_reg;
    assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_irq_pend16.sv
// Scoreboard bench for irq_pend16: driver runs a behavioural model and queues per-cycle
// expectations; a monitor pops them after each clock edge and compares against the DUT.
module tb_irq_pend16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        mask_we;
    logic [15:0] mask_wd;
    logic        ack;
    logic [3:0]  ack_idx;
    logic [15:0] d;
    logic        irq;
    logic [15:0] pend;
    logic [15:0] mask;
    logic [15:0] ovf;
    logic [15:0] ovf_clr;
    logic        ack_err;

    always #5 clk = ~clk;

    irq_pend16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .ack     (ack),
        .ack_idx (ack_idx),
        .d       (d),
        .irq     (irq),
        .pend    (pend),
        .mask    (mask),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .ack_err (ack_err)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] pend;
        logic [15:0] mask;
        logic [15:0] ovf;
        logic        irq;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: phase 0 = waiting, 1 = snapshot outstanding, 2 = forced low cycle
    logic [15:0] m_pend, m_mask, m_ovf, m_d, m_prev;
    logic        m_irq, m_err;
    int          m_phase;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Advance the model by one clock edge with the currently driven inputs, queue the
    // expectation, then let the edge happen and release one-cycle strobes.
    task automatic cycle();
        logic [15:0] rise, n_pend, n_ovf;
        logic        legal, cl;
        exp_t        e;
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_ovf = '0; m_d = '0;
            m_irq = 1'b0; m_err = 1'b0; m_phase = 0; m_prev = req;
        end else begin
            rise  = req & ~m_prev;
            legal = (m_phase == 1) && ack && m_d[ack_idx];
            n_pend = m_pend;
            n_ovf  = m_ovf;
            for (int i = 0; i < 16; i++) begin
                cl = legal && (int'(ack_idx) == i);
                if (ovf_clr[i]) n_ovf[i] = 1'b0;
                if (cl) n_pend[i] = 1'b0;
                if (rise[i]) begin
                    if (m_pend[i] && !cl) n_ovf[i] = 1'b1;
                    n_pend[i] = 1'b1;
                end
            end
            case (m_phase)
                0: begin
                    if ((m_pend & m_mask) != 16'h0) begin
                        m_d = m_pend & m_mask; m_irq = 1'b1; m_phase = 1;
                    end else begin
                        m_d = '0; m_irq = 1'b0;
                    end
                end
                1: if (legal) begin m_d = '0; m_irq = 1'b0; m_phase = 2; end
                default: begin m_d = '0; m_irq = 1'b0; m_phase = 0; end
            endcase
            m_err = ack && !legal;
            if (mask_we) m_mask = mask_wd;
            m_pend = n_pend;
            m_ovf  = n_ovf;
            m_prev = req;
        end
        if (ack) $display("[TB] ack idx=%0d d=%h legal=%0d", ack_idx, d, !m_err);
        e.d = m_d; e.pend = m_pend; e.mask = m_mask; e.ovf = m_ovf;
        e.irq = m_irq; e.err = m_err;
        sb_q.push_back(e);
        @(negedge clk);
        ack = 1'b0; mask_we = 1'b0; ovf_clr = '0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: every edge the DUT presents registered outputs; compare with the queued model
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("d",       d,                e.d);
                chk("irq",     {15'h0, irq},     {15'h0, e.irq});
                chk("pend",    pend,             e.pend);
                chk("mask",    mask,             e.mask);
                chk("ovf",     ovf,              e.ovf);
                chk("ack_err", {15'h0, ack_err}, {15'h0, e.err});
                if (irq) chk("d_nonzero_in_req", {15'h0, (d != 16'h0)}, 16'h0001);
            end
        end
    end

    initial begin
        int s;
        rst_n = 1'b0; req = 16'h0001; mask_we = 1'b0; mask_wd = '0;
        ack = 1'b0; ack_idx = '0; ovf_clr = '0;
        @(negedge clk);

        // Line high through reset release produces no event
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        chk("dir_reset_pend", pend, 16'h0000);
        chk("dir_reset_irq", {15'h0, irq}, 16'h0000);
        mask_we = 1'b1; mask_wd = 16'hFFFF; cycle();
        req = 16'h0000; cycle();
        req = 16'h0001; cycle(); cycle();
        chk("dir_rise_irq", {15'h0, irq}, 16'h0001);
        chk("dir_rise_d", d, 16'h0001);
        ack = 1'b1; ack_idx = 4'd0; cycle();
        cycles(2);

        // Masked-off line pends but raises nothing until enabled
        mask_we = 1'b1; mask_wd = 16'hFFDF; cycle();
        req = 16'h0021; cycle();
        req = 16'h0001; cycle();
        chk("dir_mask_pend", pend, 16'h0020);
        chk("dir_mask_irq", {15'h0, irq}, 16'h0000);
        mask_we = 1'b1; mask_wd = 16'hFFFF; cycle(); cycle();
        chk("dir_unmask_irq", {15'h0, irq}, 16'h0001);
        chk("dir_unmask_d", d, 16'h0020);
        ack = 1'b1; ack_idx = 4'd2; cycle();
        chk("dir_bad_ack_err", {15'h0, ack_err}, 16'h0001);
        chk("dir_bad_ack_d", d, 16'h0020);
        chk("dir_bad_ack_irq", {15'h0, irq}, 16'h0001);
        ack = 1'b1; ack_idx = 4'd5; cycle();
        cycles(2);
        ack = 1'b1; ack_idx = 4'd0; cycle();
        chk("dir_idle_ack_err", {15'h0, ack_err}, 16'h0001);
        chk("dir_idle_ack_irq", {15'h0, irq}, 16'h0000);

        // Two lines together, acknowledged one at a time
        req = 16'h1009; cycle(); cycle();
        chk("dir_two_d", d, 16'h1008);
        ack = 1'b1; ack_idx = 4'd12; cycle();
        chk("dir_two_pend", pend, 16'h0008);
        chk("dir_gap_irq", {15'h0, irq}, 16'h0000);
        cycle();
        chk("dir_idle_irq", {15'h0, irq}, 16'h0000);
        cycle();
        chk("dir_second_d", d, 16'h0008);
        ack = 1'b1; ack_idx = 4'd3; cycle();
        chk("dir_last_irq", {15'h0, irq}, 16'h0000);
        cycles(2);
        chk("dir_done_irq", {15'h0, irq}, 16'h0000);
        req = 16'h0001; cycle();

        // Overrun, clear, and a new edge coinciding with the ack of the same line
        req = 16'h0081; cycle();
        req = 16'h0001; cycle();
        req = 16'h0081; cycle();
        req = 16'h0001; cycle();
        chk("dir_ovf_set", ovf, 16'h0080);
        ovf_clr = 16'h0080; cycle();
        chk("dir_ovf_clr", ovf, 16'h0000);
        req = 16'h0081; ack = 1'b1; ack_idx = 4'd7; cycle();
        chk("dir_setwins_pend", pend & 16'h0080, 16'h0080);
        chk("dir_setwins_ovf", ovf, 16'h0000);
        cycles(3);
        chk("dir_rereq_irq", {15'h0, irq}, 16'h0001);
        rst_n = 1'b0; cycle();
        chk("dir_rst_irq", {15'h0, irq}, 16'h0000);
        chk("dir_rst_d", d, 16'h0000);
        chk("dir_rst_pend", pend, 16'h0000);
        chk("dir_rst_mask", mask, 16'h0000);
        rst_n = 1'b1; cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) req = req ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                mask_we = 1'b1;
                mask_wd = 16'($urandom() | $urandom());
            end
            if ($urandom_range(0, 15) == 0) ovf_clr = 16'($urandom());
            if (irq && $urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, 15);
                ack = 1'b1;
                for (int k = 15; k >= 0; k--)
                    if (d[(s + k) % 16]) ack_idx = 4'((s + k) % 16);
            end else if ($urandom_range(0, 24) == 0) begin
                ack = 1'b1;
                ack_idx = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        chk("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
